hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters SHALL be: STALL_TIMEOUT, default 16, consecutive stall cycles before the timeout error; CNT_W, default 16, width of the performance counters.
REQ-002 Ports SHALL be, as name direction width meaning:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- ValidD  in  1  decode holds a valid instruction.
- RS1_D  in  5  decode source register 1.
- RS2_D  in  5  decode source register 2.
- RD_D  in  5  decode destination register.
- RegWriteD  in  1  decode instruction writes the register file.
- PCSrcE  in  1  branch taken, resolved in execute.
- RegWriteW  in  1  writeback write enable.
- RDW  in  5  writeback destination register.
- StallF  out  1  hold the fetch PC.
- StallD  out  1  hold the decode register.
- FlushD  out  1  clear the decode register.
- FlushE  out  1  insert a bubble into execute.
- ErrTimeout  out  1  sticky stall-timeout error.

Function
REQ-003 The block SHALL keep a 32-bit pending scoreboard, with one bit per register; bit 0 SHALL always read 0.
REQ-004 Issue SHALL occur when ValidD=1, StallD=0 and FlushD=0.
REQ-005 On issue with RegWriteD=1 and RD_D!=0, pending[RD_D] SHALL be set at the next edge.
REQ-006 When RegWriteW=1 and RDW!=0, pending[RDW] SHALL be cleared at the next edge.
REQ-007 If a set and a clear hit the same register in the same cycle, the set SHALL win.
REQ-008 hazard SHALL be ValidD AND ((pending[RS1_D] AND NOT(RegWriteW AND RDW==RS1_D)) OR (pending[RS2_D] AND NOT(RegWriteW AND RDW==RS2_D))); the W-stage match bypasses the stall because the register file writes mid-cycle.
REQ-009 The FSM SHALL have the states RUN, STALL and FLUSH.
REQ-010 Outputs in RUN with no hazard and PCSrcE=0 SHALL all be 0.
REQ-011 A hazard with PCSrcE=0 SHALL, combinationally in the same cycle, assert StallF=1, StallD=1, FlushE=1 and FlushD=0; the next state SHALL be STALL.
REQ-012 STALL SHALL hold the same outputs while hazard=1 and SHALL return to RUN in the cycle hazard drops, with outputs 0 in that cycle.
REQ-013 PCSrcE=1 in any state SHALL take priority: FlushD=1, FlushE=1, StallF=0, StallD=0, no issue, next state FLUSH.
REQ-014 FLUSH SHALL last exactly one cycle: FlushD=1, FlushE=0, no issue, next state RUN.
REQ-015 PCSrcE=1 while in FLUSH SHALL re-enter FLUSH and apply REQ-013 outputs.
REQ-016 A 5-bit saturating stall_run counter SHALL increment each cycle StallD=1 and clear when StallD=0.
REQ-017 ErrTimeout SHALL set when stall_run reaches STALL_TIMEOUT and SHALL clear only on reset.
REQ-018 The flush path SHALL have zero-cycle latency, combinational from PCSrcE; all other state SHALL update on rising clk.

Reset
REQ-019 rst=0 SHALL asynchronously force state=RUN, scoreboard=0, stall_run=0, ErrTimeout=0 and the counters to 0.
REQ-020 Reset mid-stall or mid-flush SHALL drive all outputs to 0 within the reset cycle and discard all pending bits.

Configuration
REQ-021 With HAZARD_PERF_EN defined, the block SHALL add the outputs StallCount[CNT_W-1:0], counting cycles with StallD=1, and FlushCount[CNT_W-1:0], counting PCSrcE=1 events; both SHALL saturate at all-ones.
REQ-022 Without HAZARD_PERF_EN, those ports and their counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-023 A package hazard_pkg SHALL hold the state enum (RUN, STALL, FLUSH), REG_ADDR_W=5, NUM_REGS=32 and DATA_W=24.
REQ-024 The scoreboard SHALL be a sub-module named hazard_scoreboard, taking set/clear ports and two read ports and returning the pending bits.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Reset: rst=0 then 1 -> all outputs 0, scoreboard 0.
- Load-use: issue RD_D=1; next cycle RS1_D=1 -> StallF=StallD=FlushE=1; hold 2 cycles; RegWriteW=1 with RDW=1 -> stall drops the same cycle, pending[1]=0.
- Branch: PCSrcE=1 during a hazard -> FlushD=FlushE=1, StallD=0; next cycle FlushD=1, FlushE=0; third cycle RUN.
- Register 0: RD_D=0 with RegWriteD=1 issued, then RS2_D=0 -> no stall, ever.
- Same-cycle set and clear on register 3 -> pending[3]=1 afterwards.
- Timeout: hold pending[4] for 16 cycles with RS1_D=4 -> ErrTimeout=1, and it stays 1 after the stall clears; with HAZARD_PERF_EN, StallCount=16.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_pkg : shared types and constants for the hazard controller.         |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
package hazard_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int NUM_REGS    = 32;
  localparam int DATA_W      = 24;
  localparam int STALL_RUN_W = 5;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  typedef enum logic [1:0] {
    RUN   = ST_RUN,
    STALL = ST_STALL,
    FLUSH = ST_FLUSH
  } state_e;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic flush_d;
    logic flush_e;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE   = 4'b0000;
  localparam ctrl_t CTRL_STALL  = 4'b1101;
  localparam ctrl_t CTRL_BRANCH = 4'b0011;
  localparam ctrl_t CTRL_FLUSH  = 4'b0010;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_ctrl_if : pipeline-side signals of the hazard controller.           |
// | Optional StallCount/FlushCount exist when HAZARD_PERF_EN is defined.       |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import hazard_pkg::*;

  logic      ValidD;
  reg_addr_t RS1_D;
  reg_addr_t RS2_D;
  reg_addr_t RD_D;
  logic      RegWriteD;
  logic      PCSrcE;
  logic      RegWriteW;
  reg_addr_t RDW;
  logic      StallF;
  logic      StallD;
  logic      FlushD;
  logic      FlushE;
  logic      ErrTimeout;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;
`endif

  modport master (
    output ValidD, RS1_D, RS2_D, RD_D, RegWriteD, PCSrcE, RegWriteW, RDW,
`ifdef HAZARD_PERF_EN
    input  StallCount, FlushCount,
`endif
    input  StallF, StallD, FlushD, FlushE, ErrTimeout
  );

  modport slave (
    input  ValidD, RS1_D, RS2_D, RD_D, RegWriteD, PCSrcE, RegWriteW, RDW,
`ifdef HAZARD_PERF_EN
    output StallCount, FlushCount,
`endif
    output StallF, StallD, FlushD, FlushE, ErrTimeout
  );

endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_scoreboard : one pending bit per register, set wins over clear.     |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  wire logic      clk,
  input  wire logic      rst,
  input  wire logic      set_en,
  input  wire reg_addr_t set_addr,
  input  wire logic      clr_en,
  input  wire reg_addr_t clr_addr,
  input  wire reg_addr_t rd_addr_a,
  input  wire reg_addr_t rd_addr_b,
  output logic           rd_pend_a,
  output logic           rd_pend_b
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_addr] = 1'b0;
    if (set_en) pending_d[set_addr] = 1'b1;
    // x0 is hard-wired, so it can never be outstanding
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending_q <= '0;
    else      pending_q <= pending_d;
  end

  assign rd_pend_a = pending_q[rd_addr_a];
  assign rd_pend_b = pending_q[rd_addr_b];

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_ctrl : scoreboard-based stall/flush control for a 5-stage pipeline. |
// | Optional performance counters enabled by HAZARD_PERF_EN.                   |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int STALL_TIMEOUT = 16,
  parameter int CNT_W         = 16
) (
  input wire logic     clk,
  input wire logic     rst,
  hazard_ctrl_if.slave bus
);

  logic   pend_rs1;
  logic   pend_rs2;
  logic   byp_rs1;
  logic   byp_rs2;
  logic   hazard;
  logic   issue;
  logic   sb_set;
  logic   sb_clr;
  ctrl_t  ctrl;
  state_e state_q;
  state_e state_d;

  logic [STALL_RUN_W-1:0] stall_run_q;
  logic [STALL_RUN_W-1:0] stall_run_d;
  logic                   err_timeout_q;
  logic                   err_timeout_d;

  hazard_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (sb_set),
    .set_addr  (bus.RD_D),
    .clr_en    (sb_clr),
    .clr_addr  (bus.RDW),
    .rd_addr_a (bus.RS1_D),
    .rd_addr_b (bus.RS2_D),
    .rd_pend_a (pend_rs1),
    .rd_pend_b (pend_rs2)
  );

  // Writeback lands in the register file mid-cycle, so a W match is not a hazard
  assign byp_rs1 = bus.RegWriteW && (bus.RDW == bus.RS1_D);
  assign byp_rs2 = bus.RegWriteW && (bus.RDW == bus.RS2_D);
  assign hazard  = bus.ValidD && ((pend_rs1 && !byp_rs1) || (pend_rs2 && !byp_rs2));

  always_comb begin
    state_d = state_q;
    ctrl    = CTRL_IDLE;
    if (bus.PCSrcE) begin
      ctrl    = CTRL_BRANCH;
      state_d = FLUSH;
    end else if (state_q == FLUSH) begin
      ctrl    = CTRL_FLUSH;
      state_d = RUN;
    end else if (hazard) begin
      ctrl    = CTRL_STALL;
      state_d = STALL;
    end else begin
      state_d = RUN;
    end
    // Outputs are forced quiet for the whole reset cycle, including the PCSrcE path
    if (!rst) ctrl = CTRL_IDLE;
  end

  assign issue  = bus.ValidD && !ctrl.stall_d && !ctrl.flush_d;
  assign sb_set = issue && bus.RegWriteD && (bus.RD_D != '0);
  assign sb_clr = bus.RegWriteW && (bus.RDW != '0);

  always_comb begin
    stall_run_d = '0;
    if (ctrl.stall_d) begin
      stall_run_d = (stall_run_q == '1) ? stall_run_q : stall_run_q + STALL_RUN_W'(1);
    end
    err_timeout_d = err_timeout_q
                  || (ctrl.stall_d && (int'(stall_run_d) == STALL_TIMEOUT));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      stall_run_q   <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      stall_run_q   <= stall_run_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign bus.StallF     = ctrl.stall_f;
  assign bus.StallD     = ctrl.stall_d;
  assign bus.FlushD     = ctrl.flush_d;
  assign bus.FlushE     = ctrl.flush_e;
  assign bus.ErrTimeout = err_timeout_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (ctrl.stall_d && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (bus.PCSrcE && (flush_cnt_q != '1))   flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.StallCount = stall_cnt_q;
  assign bus.FlushCount = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// Directed bench for hazard_ctrl: rule-level reference model checked every cycle
// plus hand-computed expectations at key points of each scenario.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int CW      = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) bus ();

  hazard_ctrl #(.STALL_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return {28'd0, bus.StallF, bus.StallD, bus.FlushD, bus.FlushE};
  endfunction

  // Reference model state, as of the most recent rising edge
  bit m_pend [32];
  bit m_prev_br;
  int m_run;
  bit m_err;
  int m_scnt;
  int m_fcnt;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_prev_br = 1'b0;
    m_run     = 0;
    m_err     = 1'b0;
    m_scnt    = 0;
    m_fcnt    = 0;
  endtask

  task automatic model_cycle();
    logic [31:0] pv;
    bit haz, issue, e_sf, e_sd, e_fd, e_fe;
    int rs1, rs2, rd, rdw;
    if (!rst) begin
      chk("rst_ctrl", outs(), 32'd0);
      chk("rst_err", {31'd0, bus.ErrTimeout}, 32'd0);
      chk("rst_pending", dut.u_sb.pending_q, 32'd0);
      model_reset();
      return;
    end
    for (int i = 0; i < 32; i++) pv[i] = m_pend[i];
    chk("pending", dut.u_sb.pending_q, pv);
    chk("err", {31'd0, bus.ErrTimeout}, {31'd0, m_err});
`ifdef HAZARD_PERF_EN
    chk("stall_count", 32'(bus.StallCount), m_scnt);
    chk("flush_count", 32'(bus.FlushCount), m_fcnt);
`endif
    rs1 = int'(bus.RS1_D);
    rs2 = int'(bus.RS2_D);
    rd  = int'(bus.RD_D);
    rdw = int'(bus.RDW);
    haz = bus.ValidD && ((m_pend[rs1] && !(bus.RegWriteW && rdw == rs1)) ||
                         (m_pend[rs2] && !(bus.RegWriteW && rdw == rs2)));
    e_sf = 0; e_sd = 0; e_fd = 0; e_fe = 0;
    if (bus.PCSrcE) begin
      e_fd = 1; e_fe = 1;
    end else if (m_prev_br) begin
      e_fd = 1;
    end else if (haz) begin
      e_sf = 1; e_sd = 1; e_fe = 1;
    end
    chk("ctrl", outs(), {28'd0, e_sf, e_sd, e_fd, e_fe});
    issue = bus.ValidD && !e_sd && !e_fd;
    if (bus.RegWriteW && rdw != 0) m_pend[rdw] = 1'b0;
    if (issue && bus.RegWriteD && rd != 0) m_pend[rd] = 1'b1;
    m_prev_br = bus.PCSrcE;
    m_run = e_sd ? ((m_run < 31) ? m_run + 1 : 31) : 0;
    if (m_run == TIMEOUT) m_err = 1'b1;
    if (e_sd && m_scnt < (1 << CW) - 1) m_scnt++;
    if (bus.PCSrcE && m_fcnt < (1 << CW) - 1) m_fcnt++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      model_cycle();
    end
  end

  // One cycle of stimulus: inputs change just after the rising edge, return at the falling edge
  task automatic drive(input bit rn, input bit v, input int rs1, input int rs2, input int rd,
                       input bit rwd, input bit pc, input bit rww, input int rdw);
    @(posedge clk);
    #2;
    rst           = rn;
    bus.ValidD    = v;
    bus.RS1_D     = 5'(rs1);
    bus.RS2_D     = 5'(rs2);
    bus.RD_D      = 5'(rd);
    bus.RegWriteD = rwd;
    bus.PCSrcE    = pc;
    bus.RegWriteW = rww;
    bus.RDW       = 5'(rdw);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Expected order: StallF, StallD, FlushD, FlushE
  task automatic lit(input string name, input logic [3:0] exp);
    chk(name, outs(), {28'd0, exp});
  endtask

  initial begin
    bus.ValidD = 0; bus.RS1_D = '0; bus.RS2_D = '0; bus.RD_D = '0;
    bus.RegWriteD = 0; bus.PCSrcE = 0; bus.RegWriteW = 0; bus.RDW = '0;

    // Reset, including a branch request that must stay masked
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    lit("reset_ctrl", 4'b0000);
    chk("reset_pending", dut.u_sb.pending_q, 32'd0);
    chk("reset_err", {31'd0, bus.ErrTimeout}, 32'd0);
    idle();
    lit("post_reset_ctrl", 4'b0000);

    // Load-use on x1
    drive(1, 1, 0, 0, 1, 1, 0, 0, 0);
    lit("lu_issue", 4'b0000);
    drive(1, 1, 1, 0, 2, 1, 0, 0, 0);
    lit("lu_stall1", 4'b1101);
    drive(1, 1, 1, 0, 2, 1, 0, 0, 0);
    lit("lu_stall2", 4'b1101);
    drive(1, 1, 1, 0, 2, 1, 0, 1, 1);
    lit("lu_wb_release", 4'b0000);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 2);
    chk("lu_pending", dut.u_sb.pending_q, 32'h0000_0004);

    // Branch during a hazard, then back-to-back branches
    drive(1, 1, 0, 0, 5, 1, 0, 0, 0);
    drive(1, 1, 5, 0, 6, 1, 1, 0, 0);
    lit("br_taken", 4'b0011);
    drive(1, 1, 0, 0, 7, 1, 0, 0, 0);
    lit("br_flush", 4'b0010);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    lit("br_run", 4'b0000);
    chk("br_pending", dut.u_sb.pending_q, 32'h0000_0020);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
    lit("br2_first", 4'b0011);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
    lit("br2_reenter", 4'b0011);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    lit("br2_flush", 4'b0010);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 5);
    lit("br2_run", 4'b0000);

    // Register 0 is never pending
    drive(1, 1, 0, 0, 0, 1, 0, 0, 0);
    lit("r0_issue", 4'b0000);
    drive(1, 1, 0, 0, 0, 1, 0, 0, 0);
    lit("r0_use", 4'b0000);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    lit("r0_use2", 4'b0000);
    chk("r0_pending", dut.u_sb.pending_q, 32'd0);

    // Set and clear of x3 in the same cycle
    drive(1, 1, 0, 0, 3, 1, 0, 1, 3);
    lit("sc_issue", 4'b0000);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("sc_pending", dut.u_sb.pending_q, 32'h0000_0008);
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0);
    lit("sc_stall", 4'b1101);
    drive(1, 1, 0, 3, 0, 0, 0, 1, 3);
    lit("sc_bypass", 4'b0000);
    idle();
    chk("sc_cleared", dut.u_sb.pending_q, 32'd0);

    // Stall timeout on x4, counters start from a fresh reset
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    drive(1, 1, 0, 0, 4, 1, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      drive(1, 1, 4, 0, 0, 0, 0, 0, 0);
      lit("to_stall", 4'b1101);
    end
    chk("to_err_before", {31'd0, bus.ErrTimeout}, 32'd0);
    drive(1, 1, 4, 0, 0, 0, 0, 1, 4);
    lit("to_release", 4'b0000);
    chk("to_err_set", {31'd0, bus.ErrTimeout}, 32'd1);
`ifdef HAZARD_PERF_EN
    chk("to_stall_count", 32'(bus.StallCount), 32'd16);
    chk("to_flush_count", 32'(bus.FlushCount), 32'd0);
`endif
    idle();
    chk("to_err_sticky", {31'd0, bus.ErrTimeout}, 32'd1);

    // Asynchronous reset mid-stall and mid-flush
    drive(1, 1, 0, 0, 8, 1, 0, 0, 0);
    drive(1, 1, 8, 0, 0, 0, 0, 0, 0);
    lit("rs_stall", 4'b1101);
    drive(0, 1, 8, 0, 0, 0, 1, 0, 0);
    lit("rs_mid_stall", 4'b0000);
    chk("rs_pending", dut.u_sb.pending_q, 32'd0);
    chk("rs_err", {31'd0, bus.ErrTimeout}, 32'd0);
    idle();
    lit("rs_run", 4'b0000);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
    lit("rf_branch", 4'b0011);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    lit("rf_mid_flush", 4'b0000);
    idle();
    lit("rf_run", 4'b0000);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
